// File: rtl/instr_cache_pkg.sv
// Shared cache definitions: refill FSM states and counter helpers for the fetch-side caches.
package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } cache_state_e;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    // Saturating increment for the event counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Asynchronous read by index/offset; synchronous word and tag writes; clear-all wins over tag write.
module icache_store
    import instr_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    parameter int unsigned TAG_W = 26
) (
    input  logic                       i_clk,
    input  logic                       i_clr_all,
    input  logic [$clog2(LINES)-1:0]   i_rd_index,
    input  logic [$clog2(WORDS)-1:0]   i_rd_offset,
    output logic                       o_rd_valid,
    output logic [TAG_W-1:0]           o_rd_tag,
    output logic [DATA_W-1:0]          o_rd_word,
    input  logic                       i_word_we,
    input  logic                       i_tag_we,
    input  logic [$clog2(LINES)-1:0]   i_wr_index,
    input  logic [$clog2(WORDS)-1:0]   i_wr_offset,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic [TAG_W-1:0]           i_wr_tag
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES*WORDS];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_word  = r_data[{i_rd_index, i_rd_offset}];

    always_ff @(posedge i_clk) begin
        if (i_clr_all) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Arrays hold no reset; valid bits alone qualify their contents.
    always_ff @(posedge i_clk) begin
        if (i_word_we) begin
            r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
        end
        if (i_tag_we) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache with zero-latency hits and a
// single-outstanding line refill (IDLE -> REQ -> FILL) over a beat-based memory port.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              inval,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned OB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TW = ADDR_W - IB - OB - 2;

    cache_state_e   r_state;
    logic [IB-1:0]  r_idx;
    logic [TW-1:0]  r_tag;
    logic [OB-1:0]  r_beat;
    logic           r_pending;

    logic [OB-1:0]  w_off;
    logic [IB-1:0]  w_idx;
    logic [TW-1:0]  w_tag;
    logic           w_line_valid;
    logic [TW-1:0]  w_line_tag;
    logic           w_hit;
    logic           w_word_we;
    logic           w_tag_we;
    logic           w_last_beat;
    logic           w_clr_all;
    logic           w_unused;

    assign w_off    = cpu_addr[OB+1:2];
    assign w_idx    = cpu_addr[IB+OB+1:OB+2];
    assign w_tag    = cpu_addr[ADDR_W-1:IB+OB+2];
    assign w_unused = ^cpu_addr[1:0];

    assign w_hit     = cpu_req && (r_state == IDLE) && w_line_valid && (w_line_tag == w_tag);
    assign cpu_ready = !reset && (r_state == IDLE) && (w_hit || !cpu_req);

    // Refill writes; a pending or same-cycle invalidate keeps the new line invalid.
    assign w_last_beat = (r_beat == OB'(WORDS - 1));
    assign w_word_we   = !reset && (r_state == FILL) && mem_rvalid;
    assign w_tag_we    = w_word_we && w_last_beat && !r_pending && !inval;
    assign w_clr_all   = reset || inval;

    icache_store #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TW)
    ) u_store (
        .i_clk       (clk),
        .i_clr_all   (w_clr_all),
        .i_rd_index  (w_idx),
        .i_rd_offset (w_off),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_word   (cpu_rdata),
        .i_word_we   (w_word_we),
        .i_tag_we    (w_tag_we),
        .i_wr_index  (r_idx),
        .i_wr_offset (r_beat),
        .i_wr_data   (mem_rdata),
        .i_wr_tag    (r_tag)
    );

    // Refill FSM with registered memory-side outputs and event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            r_pending  <= 1'b0;
            r_beat     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_hit && cpu_ready) begin
                hit_count <= sat_inc(hit_count);
            end
            case (r_state)
                IDLE: begin
                    if (cpu_req && !w_hit) begin
                        r_state    <= REQ;
                        mem_req    <= 1'b1;
                        mem_addr   <= {w_tag, w_idx, {(OB+2){1'b0}}};
                        r_idx      <= w_idx;
                        r_tag      <= w_tag;
                        miss_count <= sat_inc(miss_count);
                    end
                end
                REQ: begin
                    if (inval) begin
                        r_pending <= 1'b1;
                    end
                    if (mem_gnt) begin
                        r_state  <= FILL;
                        mem_req  <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                FILL: begin
                    if (inval) begin
                        r_pending <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        r_beat <= r_beat + OB'(1);
                        if (w_last_beat) begin
                            r_state   <= IDLE;
                            r_pending <= 1'b0;
                            r_beat    <= '0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: fetches push the expected word, the value is popped
// and compared when cpu_ready completes the fetch. A behavioural memory answers refills.
module tb_instr_cache;

    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        inval;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    instr_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .inval      (inval),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] sb_q[$];

    // Memory responder state
    int          gnt_delay  = 2;
    int          wait_cnt   = 0;
    int          beats_left = 0;
    int          beat_i     = 0;
    int          rsp_beat   = 0;
    int          n_refills  = 0;
    logic [31:0] burst_addr = 32'd0;
    logic [31:0] last_addr  = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    end

    always @(posedge clk) begin
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (beats_left > 0) begin
            mem_rvalid = 1'b1;
            rsp_beat   = beat_i;
            mem_rdata  = mem_word(burst_addr + 32'(4 * beat_i));
            beat_i++;
            beats_left--;
        end else if (mem_req) begin
            if (wait_cnt >= gnt_delay) begin
                mem_gnt    = 1'b1;
                burst_addr = mem_addr;
                last_addr  = mem_addr;
                beats_left = WORDS;
                beat_i     = 0;
                wait_cnt   = 0;
                n_refills++;
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic start_fetch(input logic [31:0] a);
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        sb_q.push_back(mem_word(a & 32'hFFFF_FFFC));
    endtask

    task automatic wait_ready(output int stalls, output bit ok, output logic [31:0] d);
        stalls = 0;
        @(negedge clk);
        while (!cpu_ready && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        ok = cpu_ready;
        d  = cpu_rdata;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h10; inval = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'd0) begin
            n_err++; $display("FAIL reset_mem: req=%b addr=%h want 0/0", mem_req, mem_addr);
        end
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL reset_counts: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
        @(posedge clk); #1;
        reset = 1'b0; cpu_req = 1'b0;
    endtask

    task automatic test_cold_miss();
        int st; bit ok; logic [31:0] d; logic [31:0] exp;
        start_fetch(32'h0000_0010);
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp) begin n_err++; $display("FAIL cold_data: ready=%b data=%h want 1/%h", ok, d, exp); end
        n_cmp++;
        if (last_addr !== 32'h10) begin n_err++; $display("FAIL cold_mem_addr: got %h want 00000010", last_addr); end
        n_cmp++;
        if (st < int'(WORDS + 2)) begin n_err++; $display("FAIL cold_stall: got %0d want >=%0d", st, WORDS + 2); end
        n_cmp++;
        if (miss_count !== 32'd1) begin n_err++; $display("FAIL cold_miss_count: got %0d want 1", miss_count); end
    endtask

    task automatic test_seq_hits();
        int st; bit ok; logic [31:0] d; logic [31:0] exp;
        logic [31:0] addrs [3] = '{32'h14, 32'h18, 32'h1C};
        for (int i = 0; i < 3; i++) begin
            start_fetch(addrs[i]);
            wait_ready(st, ok, d);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!ok || d !== exp || st != 0) begin
                n_err++; $display("FAIL seq_hit_%0d: ready=%b stall=%0d data=%h want 1/0/%h", i, ok, st, d, exp);
            end
        end
        idle();
        @(negedge clk);
        n_cmp++;
        if (hit_count !== 32'd4) begin n_err++; $display("FAIL seq_hit_count: got %0d want 4", hit_count); end
    endtask

    task automatic test_conflict();
        int st; bit ok; logic [31:0] d; logic [31:0] exp; int r0;
        logic [31:0] addrs [2] = '{32'h110, 32'h10};
        for (int i = 0; i < 2; i++) begin
            r0 = n_refills;
            start_fetch(addrs[i]);
            wait_ready(st, ok, d);
            exp = sb_q.pop_front();
            n_cmp++;
            if (!ok || d !== exp) begin n_err++; $display("FAIL conflict_data_%0d: ready=%b data=%h want 1/%h", i, ok, d, exp); end
            n_cmp++;
            if (n_refills - r0 != 1) begin n_err++; $display("FAIL conflict_refill_%0d: got %0d want 1", i, n_refills - r0); end
        end
        n_cmp++;
        if (miss_count !== 32'd3) begin n_err++; $display("FAIL conflict_miss_count: got %0d want 3", miss_count); end
    endtask

    task automatic test_inval_fill();
        int st; bit ok; logic [31:0] d; logic [31:0] exp; int r0; int n;
        r0 = n_refills;
        start_fetch(32'h20);
        n = 0;
        @(negedge clk);
        while (!(mem_rvalid && rsp_beat == 1) && n < 100) begin n++; @(negedge clk); end
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp) begin n_err++; $display("FAIL inval_fill_data: ready=%b data=%h want 1/%h", ok, d, exp); end
        n_cmp++;
        if (n_refills - r0 != 2) begin n_err++; $display("FAIL inval_fill_refills: got %0d want 2", n_refills - r0); end
        n_cmp++;
        if (miss_count !== 32'd5) begin n_err++; $display("FAIL inval_fill_miss_count: got %0d want 5", miss_count); end
    endtask

    task automatic test_reset_mid();
        int st; bit ok; logic [31:0] d; logic [31:0] exp; int r0; int n;
        start_fetch(32'h30);
        n = 0;
        @(negedge clk);
        while (!(mem_rvalid && rsp_beat == 1) && n < 100) begin n++; @(negedge clk); end
        reset = 1'b1; cpu_req = 1'b0;
        void'(sb_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_mid_idle_%0d: req=%b ready=%b want 0/1", i, mem_req, cpu_ready);
            end
        end
        n_cmp++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            n_err++; $display("FAIL reset_mid_counts: hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
        n = 0;
        while (beats_left > 0 && n < 50) begin n++; @(negedge clk); end
        r0 = n_refills;
        start_fetch(32'h20);
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp) begin n_err++; $display("FAIL reset_mid_data: ready=%b data=%h want 1/%h", ok, d, exp); end
        n_cmp++;
        if (n_refills - r0 != 1 || miss_count !== 32'd1) begin
            n_err++; $display("FAIL reset_mid_miss: refills=%0d miss=%0d want 1/1", n_refills - r0, miss_count);
        end
    endtask

    task automatic test_delayed_grant();
        int st; bit ok; logic [31:0] d; logic [31:0] exp;
        gnt_delay = 10;
        start_fetch(32'h40);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h40 || cpu_ready !== 1'b0) begin
                n_err++; $display("FAIL delayed_gnt_%0d: req=%b addr=%h ready=%b want 1/00000040/0", i, mem_req, mem_addr, cpu_ready);
            end
        end
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp) begin n_err++; $display("FAIL delayed_gnt_data: ready=%b data=%h want 1/%h", ok, d, exp); end
        gnt_delay = 2;
    endtask

    task automatic test_inval_hit();
        int st; bit ok; logic [31:0] d; logic [31:0] exp; int r0;
        start_fetch(32'h40);
        inval = 1'b1;
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp || st != 0) begin
            n_err++; $display("FAIL inval_hit_data: ready=%b stall=%0d data=%h want 1/0/%h", ok, st, d, exp);
        end
        @(posedge clk); #1;
        inval = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (hit_count !== 32'd3) begin n_err++; $display("FAIL inval_hit_count: got %0d want 3", hit_count); end
        r0 = n_refills;
        start_fetch(32'h40);
        wait_ready(st, ok, d);
        exp = sb_q.pop_front();
        n_cmp++;
        if (!ok || d !== exp || n_refills - r0 != 1) begin
            n_err++; $display("FAIL inval_hit_refetch: ready=%b refills=%0d data=%h want 1/1/%h", ok, n_refills - r0, d, exp);
        end
        n_cmp++;
        if (miss_count !== 32'd3) begin n_err++; $display("FAIL inval_hit_miss_count: got %0d want 3", miss_count); end
        idle();
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = 32'd0; inval = 1'b0;
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_inval_fill();
        test_reset_mid();
        test_delayed_grant();
        test_inval_hit();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
